// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and decode helper for the pipeline hazard controller.
// Opcode layout: op=[7:4], ra=[3:2], rb=[1:0].
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_IMM   = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [3:0] OP_OUT     = 4'h6;
  localparam logic [3:0] OP_IN      = 4'h7;
  localparam logic [3:0] OP_MOV     = 4'h8;
  localparam logic [3:0] OP_STORE   = 4'hc;
  localparam logic [3:0] OP_LOAD    = 4'hd;
  localparam logic [3:0] OP_LOADIMM = 4'hf;

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ld;
    logic [1:0] dst;
  } sb_entry_t;

  typedef struct packed {
    logic uses_ra;
    logic uses_rb;
    logic writes_ra;
    logic is_load;
    logic is_imm;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      4'h1, 4'h2, 4'h3: begin d.uses_ra = 1'b1; d.uses_rb = 1'b1; d.writes_ra = 1'b1; end
      4'h4, 4'h5:       begin d.uses_ra = 1'b1; d.writes_ra = 1'b1; end
      OP_OUT:           d.uses_ra = 1'b1;
      OP_IN:            d.writes_ra = 1'b1;
      OP_MOV:           begin d.uses_rb = 1'b1; d.writes_ra = 1'b1; end
      OP_STORE:         begin d.uses_ra = 1'b1; d.uses_rb = 1'b1; end
      OP_LOAD:          begin d.uses_rb = 1'b1; d.writes_ra = 1'b1; d.is_load = 1'b1; end
      OP_LOADIMM:       begin d.writes_ra = 1'b1; d.is_imm = 1'b1; end
      default:          d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight destination tracker for the EX and MEM stages, plus source-match logic
// against the instruction currently sitting in ID.
module pipe_hazard_ctrl_scoreboard
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  sb_entry_t  push,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic       uses_ra,
  input  logic       uses_rb,
  output logic [1:0] ex_fwd,
  output logic [1:0] mem_fwd,
  output logic       load_use,
  output logic       raw_any
);

  sb_entry_t  ex_reg;
  sb_entry_t  mem_reg;
  logic [1:0] src [2];
  logic [1:0] src_used;
  logic [1:0] ex_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg  <= '0;
      mem_reg <= '0;
    end else begin
      ex_reg  <= push;
      mem_reg <= ex_reg;
    end
  end

  assign src[0]   = ra;
  assign src[1]   = rb;
  assign src_used = {uses_rb, uses_ra};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign ex_hit[gi]  = src_used[gi] & ex_reg.v & ex_reg.wr & (ex_reg.dst == src[gi]);
      assign mem_fwd[gi] = src_used[gi] & mem_reg.v & mem_reg.wr & (mem_reg.dst == src[gi]);
      // A load in EX has no data yet, so it can never be the forwarding source.
      assign ex_fwd[gi]  = ex_hit[gi] & ~ex_reg.ld;
    end
  endgenerate

  assign load_use = (|ex_hit) & ex_reg.ld;
  assign raw_any  = (|ex_hit) | (|mem_fwd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/immediate FSM, flush counter and registered
// operand-forwarding selects for the EX-stage muxes.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter bit FWD_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [7:0] id_ins,
  input  logic       ex_taken,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [1:0] flush_cnt_reg, flush_cnt_next;
  logic [1:0] fwd_a_reg, fwd_a_next;
  logic [1:0] fwd_b_reg, fwd_b_next;
  dec_t       dec;
  sb_entry_t  push;
  logic [1:0] ex_fwd, mem_fwd;
  logic       load_use, raw_any;
  logic       decode_active, flushing, hazard, stall_now, advance;

  assign dec           = decode(id_ins[7:4]);
  // The byte following LOADIMM is data, never an instruction.
  assign decode_active = id_valid & (state_reg != ST_IMM);
  assign flushing      = (state_reg == ST_FLUSH) | ex_taken;
  assign hazard        = FWD_EN ? load_use : raw_any;
  assign stall_now     = decode_active & hazard & ~flushing;
  assign advance       = decode_active & ~flushing & ~stall_now;

  assign push = '{v: advance, wr: dec.writes_ra, ld: dec.is_load, dst: id_ins[3:2]};

  pipe_hazard_ctrl_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .ra       (id_ins[3:2]),
    .rb       (id_ins[1:0]),
    .uses_ra  (decode_active & dec.uses_ra),
    .uses_rb  (decode_active & dec.uses_rb),
    .ex_fwd   (ex_fwd),
    .mem_fwd  (mem_fwd),
    .load_use (load_use),
    .raw_any  (raw_any)
  );

  always_comb begin
    fwd_a_next = FWD_RF;
    fwd_b_next = FWD_RF;
    if (FWD_EN && advance) begin
      if (ex_fwd[0])       fwd_a_next = FWD_EXMEM;
      else if (mem_fwd[0]) fwd_a_next = FWD_MEMWB;
      if (ex_fwd[1])       fwd_b_next = FWD_EXMEM;
      else if (mem_fwd[1]) fwd_b_next = FWD_MEMWB;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    if (state_reg == ST_FLUSH) begin
      flush_cnt_next = flush_cnt_reg - 2'd1;
      if (flush_cnt_reg <= 2'd1) state_next = ST_RUN;
    end else if (ex_taken) begin
      // The taken cycle itself is the first flush cycle.
      if (FLUSH_CYCLES > 1) begin
        state_next     = ST_FLUSH;
        flush_cnt_next = FLUSH_LOAD;
      end else begin
        state_next     = ST_RUN;
        flush_cnt_next = 2'd0;
      end
    end else if (stall_now) begin
      state_next = ST_STALL;
    end else if (advance && dec.is_imm) begin
      state_next = ST_IMM;
    end else begin
      state_next = ST_RUN;
    end
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall      = 1'b0;
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (flushing) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall_now) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      stall      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 2'd0;
      fwd_a_reg     <= FWD_RF;
      fwd_b_reg     <= FWD_RF;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      fwd_a_reg     <= fwd_a_next;
      fwd_b_reg     <= fwd_b_next;
    end
  end

  assign fwd_a_sel = rst ? FWD_RF : fwd_a_reg;
  assign fwd_b_sel = rst ? FWD_RF : fwd_b_reg;

endmodule
